// File: rtl/sha2_pkg.sv
// sha2_pkg: shared constants and round functions for the SHA-2 round engine.
//   - K512 / K256 round-constant tables (kept as two separate tables)
//   - IV512 / IV256 initial hash values, H0 first
//   - state_t: engine FSM states
//   - Sigma/sigma/Ch/Maj helpers. They work on 64-bit containers; when w64=0
//     only the low 32 bits are meaningful and the upper half returns zero.
package sha2_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit w64);
        if (w64) return (x >> n) | (x << (64 - n));
        return {32'b0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int n, input bit w64);
        if (w64) return x >> n;
        return {32'b0, x[31:0] >> n};
    endfunction

    function automatic logic [63:0] big_sig0(input logic [63:0] x, input bit w64);
        if (w64) return rotr(x, 28, 1'b1) ^ rotr(x, 34, 1'b1) ^ rotr(x, 39, 1'b1);
        return rotr(x, 2, 1'b0) ^ rotr(x, 13, 1'b0) ^ rotr(x, 22, 1'b0);
    endfunction

    function automatic logic [63:0] big_sig1(input logic [63:0] x, input bit w64);
        if (w64) return rotr(x, 14, 1'b1) ^ rotr(x, 18, 1'b1) ^ rotr(x, 41, 1'b1);
        return rotr(x, 6, 1'b0) ^ rotr(x, 11, 1'b0) ^ rotr(x, 25, 1'b0);
    endfunction

    function automatic logic [63:0] sml_sig0(input logic [63:0] x, input bit w64);
        if (w64) return rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ shr(x, 7, 1'b1);
        return rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ shr(x, 3, 1'b0);
    endfunction

    function automatic logic [63:0] sml_sig1(input logic [63:0] x, input bit w64);
        if (w64) return rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ shr(x, 6, 1'b1);
        return rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ shr(x, 10, 1'b0);
    endfunction

    function automatic logic [63:0] ch_f(input logic [63:0] e, input logic [63:0] f, input logic [63:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [63:0] maj_f(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// sha2_k_rom: combinational round-constant lookup.
//   round_idx  in  7        round number t
//   k          out WORD_W   K[t] for the configured mode (0 beyond the table)
module sha2_k_rom
    import sha2_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [6:0]        round_idx,
    output logic [WORD_W-1:0] k
);

    generate
        if (WORD_W == 64) begin : g_k512
            assign k = (round_idx < 7'd80) ? K512[round_idx] : '0;
        end else begin : g_k256
            assign k = (round_idx < 7'd64) ? K256[round_idx[5:0]] : '0;
        end
    endgenerate

endmodule

// File: rtl/sha2_round_engine.sv
// sha2_round_engine: iterative SHA-256 / SHA-512 compression, one round per clock.
//   clk, rst     clock, synchronous active-high reset
//   in_valid     block_in/init valid; accepted when in_ready is high
//   in_ready     high only in IDLE and never while rst is high
//   init         1: start from the IV, 0: chain from the current digest
//   block_in     16 words, word 0 in the MSBs
//   digest_out   chaining register H0..H7, H0 in the MSBs
//   out_valid    one-cycle pulse when digest_out holds the new result
module sha2_round_engine
    import sha2_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 init,
    input  logic [16*WORD_W-1:0] block_in,
    output logic [8*WORD_W-1:0]  digest_out,
    output logic                 out_valid
);

    localparam int ROUNDS = (WORD_W == 32) ? 64 : 80;
    localparam bit W64    = (WORD_W == 64);
    localparam logic [6:0] LAST = 7'(ROUNDS - 1);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
            $error("sha2_round_engine: WORD_W must be 32 or 64");
        end
    endgenerate

    state_t state, state_nxt;
    logic [6:0]        cnt;
    logic              ov_q;
    logic [WORD_W-1:0] hv [8];   // chaining register H0..H7
    logic [WORD_W-1:0] v  [8];   // working vars a..h
    logic [WORD_W-1:0] w  [16];  // rolling schedule window, w[0] = W[t]
    logic [WORD_W-1:0] iv [8];

    logic [WORD_W-1:0] k_t, s0_a, s1_e, ch_v, maj_v, ss0, ss1, t1, t2, w_new;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_h
            if (WORD_W == 64) begin : g_iv64
                assign iv[gi] = IV512[gi];
            end else begin : g_iv32
                assign iv[gi] = IV256[gi];
            end
            assign digest_out[(8-gi)*WORD_W-1 -: WORD_W] = hv[gi];
        end
    endgenerate

    sha2_k_rom #(.WORD_W(WORD_W)) u_k_rom (
        .round_idx (cnt),
        .k         (k_t)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    // Gated by rst so a pulse pending at reset never escapes.
    assign out_valid = ov_q && !rst;

    assign s0_a  = WORD_W'(big_sig0(64'(v[0]), W64));
    assign s1_e  = WORD_W'(big_sig1(64'(v[4]), W64));
    assign ch_v  = WORD_W'(ch_f(64'(v[4]), 64'(v[5]), 64'(v[6])));
    assign maj_v = WORD_W'(maj_f(64'(v[0]), 64'(v[1]), 64'(v[2])));
    assign ss0   = WORD_W'(sml_sig0(64'(w[1]), W64));
    assign ss1   = WORD_W'(sml_sig1(64'(w[14]), W64));
    assign t1    = v[7] + s1_e + ch_v + k_t + w[0];
    assign t2    = s0_a + maj_v;
    assign w_new = ss1 + w[9] + ss0 + w[0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROUND;
            ROUND:   if (cnt == LAST) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ov_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= iv[i];
                v[i]  <= '0;
            end
            for (int j = 0; j < 16; j++) w[j] <= '0;
        end else begin
            state <= state_nxt;
            ov_q  <= (state == FINAL);
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    for (int i = 0; i < 8; i++) begin
                        if (init) hv[i] <= iv[i];
                        v[i] <= init ? iv[i] : hv[i];
                    end
                    for (int j = 0; j < 16; j++)
                        w[j] <= block_in[(16-j)*WORD_W-1 -: WORD_W];
                end
                ROUND: begin
                    cnt  <= cnt + 7'd1;
                    v[7] <= v[6];
                    v[6] <= v[5];
                    v[5] <= v[4];
                    v[4] <= v[3] + t1;
                    v[3] <= v[2];
                    v[2] <= v[1];
                    v[1] <= v[0];
                    v[0] <= t1 + t2;
                    for (int j = 0; j < 15; j++) w[j] <= w[j+1];
                    w[15] <= w_new;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) hv[i] <= hv[i] + v[i];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_round_engine.sv
// Bench for sha2_round_engine: one SHA-256 and one SHA-512 instance, directed
// known-answer blocks plus random blocks checked against a FIPS-style model
// (full 16..R-1 schedule expansion, textbook round loop).
module tb_sha2_round_engine;
    import sha2_pkg::*;

    typedef logic [7:0][63:0]  h8_t;
    typedef logic [15:0][63:0] m16_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid32 = 1'b0, init32 = 1'b0, in_ready32, out_valid32;
    logic in_valid64 = 1'b0, init64 = 1'b0, in_ready64, out_valid64;
    logic [511:0]  blk32 = '0;
    logic [1023:0] blk64 = '0;
    logic [255:0]  digest32;
    logic [511:0]  digest64;

    int total = 0;
    int bad   = 0;
    h8_t mh32, mh64, iv32m, iv64m;

    always #5 clk = ~clk;

    sha2_round_engine #(.WORD_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .init(init32),
        .block_in(blk32), .digest_out(digest32), .out_valid(out_valid32));

    sha2_round_engine #(.WORD_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .init(init64),
        .block_in(blk64), .digest_out(digest64), .out_valid(out_valid64));

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_rot(logic [63:0] x, int n, int ww);
        if (ww == 64) return (x >> n) | (x << (64 - n));
        return ((x >> n) | (x << (32 - n))) & 64'hffffffff;
    endfunction

    function automatic h8_t compress(int ww, h8_t hin, m16_t m);
        logic [63:0] sch [80];
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2, msk, kk, s0, s1;
        int r;
        h8_t ho;
        r   = (ww == 64) ? 80 : 64;
        msk = (ww == 64) ? '1 : 64'hffffffff;
        for (int t = 0; t < 16; t++) sch[t] = m[t] & msk;
        for (int t = 16; t < r; t++) begin
            if (ww == 64) begin
                s0 = m_rot(sch[t-15], 1, 64) ^ m_rot(sch[t-15], 8, 64) ^ (sch[t-15] >> 7);
                s1 = m_rot(sch[t-2], 19, 64) ^ m_rot(sch[t-2], 61, 64) ^ (sch[t-2] >> 6);
            end else begin
                s0 = m_rot(sch[t-15], 7, 32) ^ m_rot(sch[t-15], 18, 32) ^ (sch[t-15] >> 3);
                s1 = m_rot(sch[t-2], 17, 32) ^ m_rot(sch[t-2], 19, 32) ^ (sch[t-2] >> 10);
            end
            sch[t] = (s1 + sch[t-7] + s0 + sch[t-16]) & msk;
        end
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int t = 0; t < r; t++) begin
            kk = (ww == 64) ? K512[t] : {32'b0, K256[t]};
            if (ww == 64) begin
                s1 = m_rot(e, 14, 64) ^ m_rot(e, 18, 64) ^ m_rot(e, 41, 64);
                s0 = m_rot(a, 28, 64) ^ m_rot(a, 34, 64) ^ m_rot(a, 39, 64);
            end else begin
                s1 = m_rot(e, 6, 32) ^ m_rot(e, 11, 32) ^ m_rot(e, 25, 32);
                s0 = m_rot(a, 2, 32) ^ m_rot(a, 13, 32) ^ m_rot(a, 22, 32);
            end
            t1 = (h + s1 + ((e & f) ^ (~e & g)) + kk + sch[t]) & msk;
            t2 = (s0 + ((a & b) ^ (a & c) ^ (b & c))) & msk;
            h = g; g = f; f = e; e = (d + t1) & msk;
            d = c; c = b; b = a; a = (t1 + t2) & msk;
        end
        ho[0] = (hin[0] + a) & msk; ho[1] = (hin[1] + b) & msk;
        ho[2] = (hin[2] + c) & msk; ho[3] = (hin[3] + d) & msk;
        ho[4] = (hin[4] + e) & msk; ho[5] = (hin[5] + f) & msk;
        ho[6] = (hin[6] + g) & msk; ho[7] = (hin[7] + h) & msk;
        return ho;
    endfunction

    function automatic logic [511:0] pack_h(int ww, h8_t h);
        logic [511:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (ww == 64) r[511-64*i -: 64] = h[i];
            else          r[255-32*i -: 32] = h[i][31:0];
        return r;
    endfunction

    function automatic logic [1023:0] pack_m(int ww, m16_t m);
        logic [1023:0] r = '0;
        for (int i = 0; i < 16; i++)
            if (ww == 64) r[1023-64*i -: 64] = m[i];
            else          r[511-32*i -: 32]  = m[i][31:0];
        return r;
    endfunction

    function automatic logic [1023:0] rnd_bits();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; the next posedge accepts.
    task automatic start(input int sel, input logic ini, input m16_t m);
        logic [1023:0] pb;
        chk($sformatf("ready_at_start_w%0d", sel ? 64 : 32), 512'(sel ? in_ready64 : in_ready32), 512'(1));
        if (sel == 0) begin
            pb = pack_m(32, m);
            in_valid32 = 1'b1; init32 = ini; blk32 = pb[511:0];
            if (ini) mh32 = iv32m;
            mh32 = compress(32, mh32, m);
        end else begin
            pb = pack_m(64, m);
            in_valid64 = 1'b1; init64 = ini; blk64 = pb;
            if (ini) mh64 = iv64m;
            mh64 = compress(64, mh64, m);
        end
        @(negedge clk);
        pb = rnd_bits();
        if (sel == 0) begin in_valid32 = 1'b0; blk32 = pb[511:0]; init32 = $urandom_range(0, 1); end
        else          begin in_valid64 = 1'b0; blk64 = pb;        init64 = $urandom_range(0, 1); end
    endtask

    // Entered at the negedge of cycle 1; returns at the negedge where out_valid is high.
    task automatic wait_done(input int sel, input bit poke, input int exp_lat);
        int lat = 1;
        int busy_bad = 0;
        bit seen = 0;
        bit pk;
        logic [1023:0] pb;
        while (lat < 300) begin
            if (sel ? out_valid64 : out_valid32) begin seen = 1; break; end
            if (sel ? in_ready64 : in_ready32) busy_bad++;
            if (poke) begin
                pk = (lat >= 5 && lat <= 40);
                pb = rnd_bits();
                if (sel == 0) begin in_valid32 = pk; blk32 = pb[511:0]; init32 = 1'b1; end
                else          begin in_valid64 = pk; blk64 = pb;        init64 = 1'b1; end
            end
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_w%0d", sel ? 64 : 32), 512'(seen ? lat : 0), 512'(exp_lat));
        chk($sformatf("busy_ready_w%0d", sel ? 64 : 32), 512'(busy_bad), 512'(0));
        if (sel == 0) chk("digest_model_w32", 512'(digest32), pack_h(32, mh32));
        else          chk("digest_model_w64", digest64, pack_h(64, mh64));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        m16_t abc256, abc512, two1, two2, rm;
        logic ini;
        for (int i = 0; i < 8; i++) begin
            iv32m[i] = {32'b0, IV256[i]};
            iv64m[i] = IV512[i];
        end
        abc256 = '0; abc256[0] = 64'h61626380;         abc256[15] = 64'h18;
        abc512 = '0; abc512[0] = 64'h6162638000000000; abc512[15] = 64'h18;
        two1 = '0;
        two1[0]  = 64'h61626364; two1[1]  = 64'h62636465; two1[2]  = 64'h63646566; two1[3]  = 64'h64656667;
        two1[4]  = 64'h65666768; two1[5]  = 64'h66676869; two1[6]  = 64'h6768696a; two1[7]  = 64'h68696a6b;
        two1[8]  = 64'h696a6b6c; two1[9]  = 64'h6a6b6c6d; two1[10] = 64'h6b6c6d6e; two1[11] = 64'h6c6d6e6f;
        two1[12] = 64'h6d6e6f70; two1[13] = 64'h6e6f7071; two1[14] = 64'h80000000;
        two2 = '0; two2[15] = 64'h1c0;

        // Reset values, observed while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_ready_w32", 512'(in_ready32), 512'(0));
        chk("rst_ready_w64", 512'(in_ready64), 512'(0));
        chk("rst_ovalid_w32", 512'(out_valid32), 512'(0));
        chk("rst_ovalid_w64", 512'(out_valid64), 512'(0));
        chk("rst_digest_w32", 512'(digest32), 512'(256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19));
        chk("rst_digest_w64", digest64, pack_h(64, iv64m));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_digest_w32", 512'(digest32), pack_h(32, iv32m));
        chk("post_rst_ovalid_w32", 512'(out_valid32), 512'(0));
        mh32 = iv32m; mh64 = iv64m;

        // Known-answer single blocks.
        start(0, 1'b1, abc256);
        wait_done(0, 1'b0, 66);
        chk("kat_abc256", 512'(digest32), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        start(1, 1'b1, abc512);
        wait_done(1, 1'b0, 82);
        chk("kat_abc512", digest64,
            512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f);

        // Two-block chaining, second block issued in the out_valid cycle.
        start(0, 1'b1, two1);
        wait_done(0, 1'b0, 66);
        start(0, 1'b0, two2);
        wait_done(0, 1'b0, 66);
        chk("kat_two_block", 512'(digest32), 512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));

        // in_valid hammered mid-block with other data must be ignored.
        start(0, 1'b1, abc256);
        wait_done(0, 1'b1, 66);
        chk("poke_abc256", 512'(digest32), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        start(1, 1'b0, abc512);
        wait_done(1, 1'b1, 82);

        // Random blocks with random chaining; digest must hold after the pulse.
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 16; i++) rm[i] = {$urandom, $urandom};
                ini = (k == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
                start(s, ini, rm);
                wait_done(s, 1'b0, s ? 82 : 66);
            end
        end
        repeat (3) @(negedge clk);
        chk("hold_w32", 512'(digest32), pack_h(32, mh32));
        chk("hold_w64", digest64, pack_h(64, mh64));

        // Abort mid-block with a one-cycle reset.
        start(0, 1'b1, abc256);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", 512'(in_ready32), 512'(0));
        chk("abort_ovalid_in_rst", 512'(out_valid32), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        mh32 = iv32m; mh64 = iv64m;
        chk("abort_digest_iv_w32", 512'(digest32), pack_h(32, iv32m));
        chk("abort_digest_iv_w64", digest64, pack_h(64, iv64m));
        @(negedge clk);
        chk("abort_no_ovalid", 512'(out_valid32), 512'(0));
        start(0, 1'b1, abc256);
        wait_done(0, 1'b0, 66);
        chk("abort_then_abc256", 512'(digest32), 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
